alu_dispatch: RTL and testbench

- Serial issue/writeback controller that drives the ALU's input side and consumes its output side.
- Accepts one encoded instruction at a time over a valid/ready handshake. Reads operands from an internal register file and issues them to the ALU with a one-cycle enable pulse.
- Waits a fixed ALU latency, then writes the returned result and flags back into the register file and flag register.
- Sits between instruction fetch and the ALU; a debug port allows preload and inspection of registers.

---
 rtl/alu_dispatch.sv | 180 ++++++++++++++++++
 tb/tb_alu_dispatch.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Purpose: serial issue/writeback controller between instruction fetch and a fixed-latency ALU.
// Latency: acceptance edge to register/flag writeback edge is 2+ALU_LATENCY cycles; one instruction per 3+ALU_LATENCY cycles.
// Backpressure: instr_ready is high only in IDLE; a presented instruction is held by the source until accepted.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   instr, instr_valid, instr_ready instruction handshake ([15:12] op, [11:9] dest, [8:6] src1,
//                                  [5:3] src2, [2] wb_en, [1] flags_en, [0] use_cin)
//   alu_en/opcode/dest/op1/op2/cin ALU issue side (alu_en pulses once, the rest hold)
//   alu_result/flags/dest_in       ALU return side, sampled only in WB
//   flags, busy                    architectural flags and "not IDLE" status
//   dbg_we/addr/wdata/rdata        debug register preload (IDLE only) and combinational readback
module alu_dispatch #(
   parameter int WIDTH       = 32,
   parameter int OPCODE      = 4,
   parameter int REGS_CODING = 3,
   parameter int FLAGS       = 4,
   parameter int CARRY       = 0,
   parameter int ALU_LATENCY = 1,
   parameter int INSTR_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_W-1:0]     instr,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   output logic                   alu_en,
   output logic [OPCODE-1:0]      alu_opcode,
   output logic [REGS_CODING-1:0] alu_dest,
   output logic [WIDTH-1:0]       alu_op1,
   output logic [WIDTH-1:0]       alu_op2,
   output logic                   alu_cin,
   input  logic [WIDTH-1:0]       alu_result,
   input  logic [FLAGS-1:0]       alu_flags,
   input  logic [REGS_CODING-1:0] alu_dest_in,
   output logic [FLAGS-1:0]       flags,
   output logic                   busy,
   input  logic                   dbg_we,
   input  logic [REGS_CODING-1:0] dbg_addr,
   input  logic [WIDTH-1:0]       dbg_wdata,
   output logic [WIDTH-1:0]       dbg_rdata
);

   localparam int NREGS  = 1 << REGS_CODING;
   localparam int OP_LSB = INSTR_W - OPCODE;
   localparam int DS_LSB = OP_LSB - REGS_CODING;
   localparam int S1_LSB = DS_LSB - REGS_CODING;
   localparam int S2_LSB = S1_LSB - REGS_CODING;
   localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [2:0]             wait_cnt;
   logic [WIDTH-1:0]       regs [NREGS];
   logic                   wb_en_q;
   logic                   flags_en_q;
   logic                   tag_err;
   logic                   accept;
   logic                   tag_miss;

   // Instruction field decode
   logic [OPCODE-1:0]      f_opcode;
   logic [REGS_CODING-1:0] f_dest;
   logic [REGS_CODING-1:0] f_src1;
   logic [REGS_CODING-1:0] f_src2;

   assign f_opcode = instr[OP_LSB +: OPCODE];
   assign f_dest   = instr[DS_LSB +: REGS_CODING];
   assign f_src1   = instr[S1_LSB +: REGS_CODING];
   assign f_src2   = instr[S2_LSB +: REGS_CODING];

   assign accept    = instr_valid && (state == IDLE);
   assign tag_miss  = (alu_dest_in != alu_dest);
   assign dbg_rdata = regs[dbg_addr];

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      alu_en      = 1'b0;
      busy        = 1'b1;
      unique case (state)
         IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
            if (instr_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            alu_en    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 3'd0) begin
               state_nxt = WB;
            end
         end
         WB: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Counts the remaining WAIT cycles; loaded in ISSUE so WAIT lasts ALU_LATENCY cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 3'd0;
      end else if (state == ISSUE) begin
         wait_cnt <= CNT_INIT;
      end else if (state == WAIT && wait_cnt != 3'd0) begin
         wait_cnt <= wait_cnt - 3'd1;
      end
   end

   // ---------------- Issue registers ----------------
   // Captured once at acceptance and held until the next acceptance, so the ALU
   // sees stable operands during and after the alu_en pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_opcode <= '0;
         alu_dest   <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_cin    <= 1'b0;
         wb_en_q    <= 1'b0;
         flags_en_q <= 1'b0;
      end else if (accept) begin
         alu_opcode <= f_opcode;
         alu_dest   <= f_dest;
         alu_op1    <= regs[f_src1];
         alu_op2    <= regs[f_src2];
         alu_cin    <= instr[0] & flags[CARRY];
         wb_en_q    <= instr[2];
         flags_en_q <= instr[1];
      end
   end

   // ---------------- Register file, flags, writeback ----------------
   // Debug writes only land in IDLE and WB writes only in WB, so the two never
   // collide. An operand read at acceptance sees the pre-debug-write value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         flags   <= '0;
         tag_err <= 1'b0;
      end else begin
         if (state == IDLE && dbg_we) begin
            regs[dbg_addr] <= dbg_wdata;
         end
         if (state == WB) begin
            // A returned tag that disagrees with the issued dest means the result
            // is not ours: drop both register and flag update, remember the event.
            tag_err <= tag_err | tag_miss;
            if (wb_en_q && !tag_miss) begin
               regs[alu_dest_in] <= alu_result;
            end
            if (flags_en_q && !tag_miss) begin
               flags <= alu_flags;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [15:0] instr = '0;
   logic        a_valid = 1'b0;
   logic        b_valid = 1'b0;
   logic        dbg_we = 1'b0;
   logic [2:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;

   // DUT a: ALU_LATENCY=1
   logic        a_ready, a_en, a_cin, a_busy;
   logic [3:0]  a_opc, a_flags, a_aflags;
   logic [2:0]  a_dst, a_tag;
   logic [31:0] a_op1, a_op2, a_result, a_rdata;
   // DUT b: ALU_LATENCY=3
   logic        b_ready, b_en, b_cin, b_busy;
   logic [3:0]  b_opc, b_flags, b_aflags;
   logic [2:0]  b_dst, b_tag;
   logic [31:0] b_op1, b_op2, b_result, b_rdata;

   alu_dispatch #(.ALU_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(a_valid), .instr_ready(a_ready),
      .alu_en(a_en), .alu_opcode(a_opc), .alu_dest(a_dst), .alu_op1(a_op1), .alu_op2(a_op2),
      .alu_cin(a_cin), .alu_result(a_result), .alu_flags(a_aflags), .alu_dest_in(a_tag),
      .flags(a_flags), .busy(a_busy), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(a_rdata));

   alu_dispatch #(.ALU_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(b_valid), .instr_ready(b_ready),
      .alu_en(b_en), .alu_opcode(b_opc), .alu_dest(b_dst), .alu_op1(b_op1), .alu_op2(b_op2),
      .alu_cin(b_cin), .alu_result(b_result), .alu_flags(b_aflags), .alu_dest_in(b_tag),
      .flags(b_flags), .busy(b_busy), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(b_rdata));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bench model state
   logic [31:0] mreg [8];
   logic [3:0]  mflags = '0;
   logic [71:0] sb [$];
   int a_pulses = 0;
   int a_en_last = 0;
   int a_en_prev = 0;
   logic        force_tag_en = 1'b0;
   logic [2:0]  force_tag = '0;

   // Adder ALU: returns {flags[3:0], result[31:0]}; flags = {0,0,zero,carry}
   function automatic logic [35:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic c);
      logic [32:0] s;
      s = {1'b0, x} + {1'b0, y} + {32'd0, c};
      return {2'b00, (s[31:0] == 32'd0), s[32], s[31:0]};
   endfunction

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic wb, input logic fl, input logic ci);
      return {op, d, s1, s2, wb, fl, ci};
   endfunction

   // Bench ALU models: real data only in the cycle the result is due, garbage otherwise.
   logic [2:0]  a_cnt = '0, b_cnt = '0;
   logic        a_pend = 1'b0, b_pend = 1'b0;
   logic [35:0] a_ret = '0, b_ret = '0;
   logic [2:0]  a_rtag = '0, b_rtag = '0;

   always @(posedge clk) begin
      if (rst) begin
         a_cnt <= '0; a_pend <= 1'b0;
      end else if (a_en) begin
         a_cnt <= 3'd1; a_pend <= 1'b1;
         a_ret <= alu_f(a_op1, a_op2, a_cin);
         a_rtag <= force_tag_en ? force_tag : a_dst;
      end else if (a_cnt != 3'd0) begin
         a_cnt <= a_cnt - 3'd1;
      end else begin
         a_pend <= 1'b0;
      end
   end
   assign a_result = (a_pend && a_cnt == 3'd0) ? a_ret[31:0] : 32'hDEADBEEF;
   assign a_aflags = (a_pend && a_cnt == 3'd0) ? a_ret[35:32] : 4'hA;
   assign a_tag    = (a_pend && a_cnt == 3'd0) ? a_rtag : a_dst;

   always @(posedge clk) begin
      if (rst) begin
         b_cnt <= '0; b_pend <= 1'b0;
      end else if (b_en) begin
         b_cnt <= 3'd3; b_pend <= 1'b1;
         b_ret <= alu_f(b_op1, b_op2, b_cin);
         b_rtag <= b_dst;
      end else if (b_cnt != 3'd0) begin
         b_cnt <= b_cnt - 3'd1;
      end else begin
         b_pend <= 1'b0;
      end
   end
   assign b_result = (b_pend && b_cnt == 3'd0) ? b_ret[31:0] : 32'hDEADBEEF;
   assign b_aflags = (b_pend && b_cnt == 3'd0) ? b_ret[35:32] : 4'hA;
   assign b_tag    = (b_pend && b_cnt == 3'd0) ? b_rtag : b_dst;

   // Issue-side scoreboard monitor for DUT a
   always @(negedge clk) begin
      logic [71:0] e;
      if (!rst && a_en) begin
         a_pulses++;
         a_en_prev = a_en_last;
         a_en_last = cyc;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_issue got op1=%h op2=%h required no issue", a_op1, a_op2);
         end else begin
            e = sb.pop_front();
            if ({a_opc, a_dst, a_op1, a_op2, a_cin} !== e) begin
               errors++;
               $display("FAIL sb_issue got %h required %h", {a_opc, a_dst, a_op1, a_op2, a_cin}, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dbg_write(input logic [2:0] ad, input logic [31:0] d);
      dbg_we = 1'b1; dbg_addr = ad; dbg_wdata = d;
      step();
      dbg_we = 1'b0;
      mreg[ad] = d;
   endtask

   // Presents an instruction to DUT a (leaves a_valid high) and crosses the acceptance edge.
   task automatic present(input logic [15:0] ins);
      int n;
      instr = ins; a_valid = 1'b1; n = 0;
      while (!a_ready && n < 20) begin
         step();
         n++;
      end
      if (!a_ready) begin
         checks++; errors++;
         $display("FAIL present_timeout got ready=%b required 1", a_ready);
      end
      sb.push_back({ins[15:12], ins[11:9], mreg[ins[8:6]], mreg[ins[5:3]], ins[0] & mflags[0]});
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++;
      if ({a_ready, a_busy, b_ready, b_busy} !== 4'b1010) begin
         errors++; $display("FAIL reset_handshake got %b required 1010", {a_ready, a_busy, b_ready, b_busy});
      end
      checks++;
      if ({a_en, a_opc, a_dst, a_op1, a_op2, a_cin} !== '0) begin
         errors++; $display("FAIL reset_issue_outputs got %h required 0", {a_en, a_opc, a_dst, a_op1, a_op2, a_cin});
      end
      checks++;
      if (a_flags !== 4'h0) begin
         errors++; $display("FAIL reset_flags got %h required 0", a_flags);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         mreg[i] = '0;
         step();
         checks++;
         if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_reg%0d got %h/%h required 0", i, a_rdata, b_rdata);
         end
      end
   endtask

   task automatic test_basic();
      int p0;
      dbg_write(3'd1, 32'd5);
      dbg_write(3'd2, 32'd7);
      dbg_addr = 3'd3;
      p0 = a_pulses;
      present(enc(4'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0));
      a_valid = 1'b0;
      checks++;
      if ({a_en, a_op1, a_op2, a_ready, a_busy} !== {1'b1, 32'd5, 32'd7, 1'b0, 1'b1}) begin
         errors++; $display("FAIL basic_issue got en=%b op1=%h op2=%h rdy=%b required 1/5/7/0", a_en, a_op1, a_op2, a_ready);
      end
      step();
      checks++;
      if ({a_en, a_op1, a_op2} !== {1'b0, 32'd5, 32'd7}) begin
         errors++; $display("FAIL basic_hold got en=%b op1=%h op2=%h required 0/5/7", a_en, a_op1, a_op2);
      end
      step();
      checks++;
      if (a_rdata !== 32'd0) begin
         errors++; $display("FAIL basic_early_wb got R3=%h required 0", a_rdata);
      end
      step();
      mreg[3] = 32'd12; mflags = 4'h0;
      checks++;
      if (a_rdata !== 32'd12 || a_flags !== 4'h0) begin
         errors++; $display("FAIL basic_wb got R3=%h flags=%h required 12/0", a_rdata, a_flags);
      end
      checks++;
      if (a_pulses - p0 != 1 || a_ready !== 1'b1) begin
         errors++; $display("FAIL basic_pulses got %0d rdy=%b required 1/1", a_pulses - p0, a_ready);
      end
   endtask

   task automatic test_carry();
      dbg_write(3'd4, 32'hFFFF_FFFF);
      dbg_write(3'd5, 32'd1);
      dbg_write(3'd6, 32'h66);
      dbg_addr = 3'd6;
      present(enc(4'd0, 3'd6, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0));
      a_valid = 1'b0;
      checks++;
      if (a_cin !== 1'b0) begin
         errors++; $display("FAIL carry_cin_off got %b required 0", a_cin);
      end
      repeat (3) step();
      mreg[6] = 32'd0; mflags = 4'b0011;
      checks++;
      if (a_rdata !== 32'd0 || a_flags !== 4'b0011) begin
         errors++; $display("FAIL carry_wb got R6=%h flags=%b required 0/0011", a_rdata, a_flags);
      end
      dbg_addr = 3'd7;
      present(enc(4'd0, 3'd7, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1));
      a_valid = 1'b0;
      checks++;
      if (a_cin !== 1'b1) begin
         errors++; $display("FAIL carry_cin_on got %b required 1", a_cin);
      end
      repeat (3) step();
      mreg[7] = 32'd3; mflags = 4'b0000;
      checks++;
      if (a_rdata !== 32'd3 || a_flags !== 4'b0000) begin
         errors++; $display("FAIL carry_use got R7=%h flags=%b required 3/0000", a_rdata, a_flags);
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      dbg_addr = 3'd0;
      p0 = a_pulses;
      present(enc(4'd0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0));
      instr = enc(4'd0, 3'd3, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (a_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready1_c%0d got %b required 0", k, a_ready);
         end
         step();
      end
      present(enc(4'd0, 3'd3, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0));
      a_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (a_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready2_c%0d got %b required 0", k, a_ready);
         end
         step();
      end
      mreg[0] = 32'd12; mreg[3] = 32'd14;
      checks++;
      if (a_pulses - p0 != 2 || a_en_last - a_en_prev != 4) begin
         errors++; $display("FAIL b2b_pulses got n=%0d gap=%0d required 2/4", a_pulses - p0, a_en_last - a_en_prev);
      end
      checks++;
      if (a_rdata !== 32'd12) begin
         errors++; $display("FAIL b2b_r0 got %h required 12", a_rdata);
      end
      dbg_addr = 3'd3;
      step();
      checks++;
      if (a_rdata !== 32'd14) begin
         errors++; $display("FAIL b2b_r3 got %h required 14", a_rdata);
      end
   endtask

   task automatic test_disabled();
      dbg_write(3'd6, 32'h66);
      dbg_addr = 3'd3;
      present(enc(4'd0, 3'd3, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0));
      a_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (a_rdata !== mreg[3] || a_flags !== mflags) begin
         errors++; $display("FAIL wb_disabled got R3=%h flags=%h required %h/%h", a_rdata, a_flags, mreg[3], mflags);
      end
      force_tag_en = 1'b1; force_tag = 3'd6;
      present(enc(4'd0, 3'd3, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0));
      a_valid = 1'b0;
      repeat (3) step();
      force_tag_en = 1'b0;
      checks++;
      if (a_rdata !== mreg[3] || a_flags !== mflags) begin
         errors++; $display("FAIL tag_miss_dest got R3=%h flags=%h required %h/%h", a_rdata, a_flags, mreg[3], mflags);
      end
      dbg_addr = 3'd6;
      step();
      checks++;
      if (a_rdata !== 32'h66) begin
         errors++; $display("FAIL tag_miss_r6 got %h required 66", a_rdata);
      end
   endtask

   task automatic test_latency();
      dbg_write(3'd1, 32'd5);
      dbg_write(3'd2, 32'd9);
      dbg_addr = 3'd3;
      instr = enc(4'd0, 3'd3, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0);
      b_valid = 1'b1;
      checks++;
      if (b_ready !== 1'b1) begin
         errors++; $display("FAIL lat_ready got %b required 1", b_ready);
      end
      step();
      b_valid = 1'b0;
      checks++;
      if ({b_en, b_opc, b_dst, b_op1, b_op2} !== {1'b1, 4'd0, 3'd3, 32'd5, 32'd9}) begin
         errors++; $display("FAIL lat_issue got en=%b dst=%0d op1=%h op2=%h required 1/3/5/9", b_en, b_dst, b_op1, b_op2);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (b_rdata !== 32'd0 || b_busy !== 1'b1) begin
            errors++; $display("FAIL lat_wait_c%0d got R3=%h busy=%b required 0/1", k, b_rdata, b_busy);
         end
         step();
      end
      checks++;
      if (b_rdata !== 32'd14 || b_flags !== 4'h0 || b_ready !== 1'b1) begin
         errors++; $display("FAIL lat_wb got R3=%h flags=%h rdy=%b required 14/0/1", b_rdata, b_flags, b_ready);
      end
   endtask

   task automatic test_reset_mid();
      present(enc(4'd0, 3'd5, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0));
      a_valid = 1'b0;
      dbg_we = 1'b1; dbg_addr = 3'd7; dbg_wdata = 32'h77;
      step();
      dbg_we = 1'b0;
      checks++;
      if (a_rdata !== mreg[7]) begin
         errors++; $display("FAIL busy_dbg_write got R7=%h required %h", a_rdata, mreg[7]);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({a_ready, a_busy, a_en, a_flags} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         errors++; $display("FAIL midrst_state got rdy=%b busy=%b en=%b flags=%h required 1/0/0/0", a_ready, a_busy, a_en, a_flags);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         mreg[i] = '0;
         step();
         checks++;
         if (a_rdata !== 32'd0) begin
            errors++; $display("FAIL midrst_reg%0d got %h required 0", i, a_rdata);
         end
      end
      mflags = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_back_to_back();
      test_disabled();
      test_latency();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover got %0d required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
